// File: rtl/freq_sweep_pkg.sv
// Shared types and width helpers for the frequency sweep test unit.
package freq_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ACCUM  = 3'd2,
    ST_CALC   = 3'd3,
    ST_OUTPUT = 3'd4,
    ST_NEXT   = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  function automatic int mag_w(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int acc_w(input int data_w, input int avg_log2);
    return data_w + avg_log2;
  endfunction

endpackage

// File: rtl/freq_sweep_test_unit_iq_avg.sv
// I/Q accumulator: clear/enable summing, then one calc cycle registers the
// floor-averaged I/Q and their squared magnitude.
module iq_avg_accum
  import freq_sweep_pkg::*;
#(
  parameter int DATA_W   = 10,
  parameter int AVG_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     en,
  input  logic                     calc,
  input  logic signed [DATA_W-1:0] i_in,
  input  logic signed [DATA_W-1:0] q_in,
  output logic signed [DATA_W-1:0] avg_i,
  output logic signed [DATA_W-1:0] avg_q,
  output logic [2*DATA_W-1:0]      mag_sq,
  output logic [2*DATA_W-1:0]      mag_next
);

  localparam int ACC_W = acc_w(DATA_W, AVG_LOG2);
  localparam int MAG_W = mag_w(DATA_W);

  logic signed [ACC_W-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [DATA_W-1:0] avg_i_q, avg_i_d, avg_q_q, avg_q_d;
  logic signed [DATA_W-1:0] div_i, div_q;
  logic signed [MAG_W-1:0]  sq_i, sq_q;
  logic [MAG_W-1:0]         mag_q, mag_d;

  always_comb begin
    div_i    = DATA_W'(acc_i_q >>> AVG_LOG2);
    div_q    = DATA_W'(acc_q_q >>> AVG_LOG2);
    sq_i     = MAG_W'(div_i) * MAG_W'(div_i);
    sq_q     = MAG_W'(div_q) * MAG_W'(div_q);
    // Sum can reach 2^(MAG_W-1): treat as unsigned so the top bit is magnitude.
    mag_next = $unsigned(sq_i) + $unsigned(sq_q);

    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    if (clear) begin
      acc_i_d = '0;
      acc_q_d = '0;
    end else if (en) begin
      acc_i_d = acc_i_q + ACC_W'(i_in);
      acc_q_d = acc_q_q + ACC_W'(q_in);
    end else begin
      acc_i_d = acc_i_q;
      acc_q_d = acc_q_q;
    end

    if (calc) begin
      avg_i_d = div_i;
      avg_q_d = div_q;
      mag_d   = mag_next;
    end else begin
      avg_i_d = avg_i_q;
      avg_q_d = avg_q_q;
      mag_d   = mag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
      avg_i_q <= '0;
      avg_q_q <= '0;
      mag_q   <= '0;
    end else begin
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      avg_i_q <= avg_i_d;
      avg_q_q <= avg_q_d;
      mag_q   <= mag_d;
    end
  end

  assign avg_i  = avg_i_q;
  assign avg_q  = avg_q_q;
  assign mag_sq = mag_q;

endmodule

// File: rtl/freq_sweep_test_unit.sv
// Frequency sweep controller: settle, average, compute |IQ|^2 and stream one
// record per point. Define SWEEP_PEAK_EN to add the peak_freq/peak_mag tracker.
module freq_sweep_test_unit
  import freq_sweep_pkg::*;
#(
  parameter int DATA_W     = 10,
  parameter int FREQ_W     = 14,
  parameter int AVG_LOG2   = 4,
  parameter int CLK_PER_US = 50,
  parameter int US_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [FREQ_W-1:0]        f_start,
  input  logic [FREQ_W-1:0]        f_step,
  input  logic [15:0]              n_points,
  input  logic [US_W-1:0]          settle_us,
  input  logic signed [DATA_W-1:0] i_in,
  input  logic signed [DATA_W-1:0] q_in,
  output logic [FREQ_W-1:0]        freq_o,
  output logic                     busy,
  output logic                     done,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [FREQ_W-1:0]        res_freq,
  output logic signed [DATA_W-1:0] res_i,
  output logic signed [DATA_W-1:0] res_q,
  output logic [2*DATA_W-1:0]      res_mag_sq,
  output logic                     res_last
`ifdef SWEEP_PEAK_EN
  ,
  output logic [FREQ_W-1:0]        peak_freq,
  output logic [2*DATA_W-1:0]      peak_mag
`endif
);

  localparam int MAG_W = mag_w(DATA_W);
  localparam int SET_W = US_W + 6;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] AVG_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  // Settle length minus one, never below zero so a zero delay still costs one cycle.
  function automatic logic [SET_W-1:0] settle_load(input logic [US_W-1:0] us);
    logic [SET_W-1:0] prod;
    prod = SET_W'(us) * SET_W'(CLK_PER_US);
    return (prod == '0) ? '0 : prod - SET_W'(1);
  endfunction

  state_e            state_q, state_d;
  logic [FREQ_W-1:0] freq_o_q, freq_o_d, step_q, step_d, res_freq_q, res_freq_d;
  logic [15:0]       npts_q, npts_d, idx_q, idx_d;
  logic [US_W-1:0]   settle_q, settle_d;
  logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              res_valid_q, res_valid_d, res_last_q, res_last_d;
  logic [MAG_W-1:0]  mag_next;
`ifdef SWEEP_PEAK_EN
  logic [FREQ_W-1:0] peak_freq_q, peak_freq_d;
  logic [MAG_W-1:0]  peak_mag_q, peak_mag_d;
`endif

  iq_avg_accum #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_avg (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q == ST_SETTLE),
    .en       (state_q == ST_ACCUM),
    .calc     ((state_q == ST_CALC) && !abort),
    .i_in     (i_in),
    .q_in     (q_in),
    .avg_i    (res_i),
    .avg_q    (res_q),
    .mag_sq   (res_mag_sq),
    .mag_next (mag_next)
  );

  // Next-state and registered-output logic for the sweep FSM.
  always_comb begin
    state_d      = state_q;
    freq_o_d     = freq_o_q;
    step_d       = step_q;
    npts_d       = npts_q;
    settle_d     = settle_q;
    idx_d        = idx_q;
    settle_cnt_d = settle_cnt_q;
    acc_cnt_d    = acc_cnt_q;
    res_valid_d  = res_valid_q;
    res_freq_d   = res_freq_q;
    res_last_d   = res_last_q;
    done_d       = 1'b0;
`ifdef SWEEP_PEAK_EN
    peak_freq_d  = peak_freq_q;
    peak_mag_d   = peak_mag_q;
`endif
    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            step_d   = f_step;
            npts_d   = n_points;
            settle_d = settle_us;
`ifdef SWEEP_PEAK_EN
            peak_freq_d = '0;
            peak_mag_d  = '0;
`endif
            if (n_points != 16'd0) begin
              state_d      = ST_SETTLE;
              freq_o_d     = f_start;
              idx_d        = 16'd0;
              settle_cnt_d = settle_load(settle_us);
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SETTLE: begin
          acc_cnt_d = '0;
          if (settle_cnt_q == '0) begin
            state_d = ST_ACCUM;
          end else begin
            settle_cnt_d = settle_cnt_q - SET_W'(1);
          end
        end
        ST_ACCUM: begin
          if (acc_cnt_q == AVG_LAST) begin
            state_d = ST_CALC;
          end else begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
          end
        end
        ST_CALC: begin
          res_freq_d  = freq_o_q;
          res_last_d  = (idx_q == (npts_q - 16'd1));
          res_valid_d = 1'b1;
          state_d     = ST_OUTPUT;
`ifdef SWEEP_PEAK_EN
          if (mag_next > peak_mag_q) begin
            peak_mag_d  = mag_next;
            peak_freq_d = freq_o_q;
          end else begin
            peak_mag_d  = peak_mag_q;
          end
`endif
        end
        ST_OUTPUT: begin
          if (res_ready) begin
            res_valid_d = 1'b0;
            if (res_last_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_NEXT;
            end
          end else begin
            res_valid_d = 1'b1;
          end
        end
        ST_NEXT: begin
          freq_o_d     = freq_o_q + step_q;
          idx_d        = idx_q + 16'd1;
          settle_cnt_d = settle_load(settle_q);
          state_d      = ST_SETTLE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      freq_o_q     <= '0;
      step_q       <= '0;
      npts_q       <= '0;
      settle_q     <= '0;
      idx_q        <= '0;
      settle_cnt_q <= '0;
      acc_cnt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      res_freq_q   <= '0;
      res_last_q   <= 1'b0;
`ifdef SWEEP_PEAK_EN
      peak_freq_q  <= '0;
      peak_mag_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      freq_o_q     <= freq_o_d;
      step_q       <= step_d;
      npts_q       <= npts_d;
      settle_q     <= settle_d;
      idx_q        <= idx_d;
      settle_cnt_q <= settle_cnt_d;
      acc_cnt_q    <= acc_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      res_valid_q  <= res_valid_d;
      res_freq_q   <= res_freq_d;
      res_last_q   <= res_last_d;
`ifdef SWEEP_PEAK_EN
      peak_freq_q  <= peak_freq_d;
      peak_mag_q   <= peak_mag_d;
`endif
    end
  end

  assign freq_o    = freq_o_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign res_valid = res_valid_q;
  assign res_freq  = res_freq_q;
  assign res_last  = res_last_q;
`ifdef SWEEP_PEAK_EN
  assign peak_freq = peak_freq_q;
  assign peak_mag  = peak_mag_q;
`endif

endmodule

// File: tb/tb_freq_sweep_test_unit.sv
// Directed bench for freq_sweep_test_unit: single-point vector table plus
// multi-cycle sequences (stall, abort, empty sweep, wrap, reset).
module tb_freq_sweep_test_unit;
  localparam int DATA_W = 10;
  localparam int FREQ_W = 14;
  localparam int US_W   = 16;
  localparam int MAG_W  = 2 * DATA_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, start, abort, res_ready;
  logic [FREQ_W-1:0]        f_start, f_step;
  logic [15:0]              n_points;
  logic [US_W-1:0]          settle_us;
  logic signed [DATA_W-1:0] i_in, q_in;
  logic [FREQ_W-1:0]        freq_o, res_freq;
  logic                     busy, done, res_valid, res_last;
  logic signed [DATA_W-1:0] res_i, res_q;
  logic [MAG_W-1:0]         res_mag_sq;
`ifdef SWEEP_PEAK_EN
  logic [FREQ_W-1:0]        peak_freq;
  logic [MAG_W-1:0]         peak_mag;
`endif

  freq_sweep_test_unit dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .f_start(f_start), .f_step(f_step), .n_points(n_points), .settle_us(settle_us),
    .i_in(i_in), .q_in(q_in), .freq_o(freq_o), .busy(busy), .done(done),
    .res_valid(res_valid), .res_ready(res_ready), .res_freq(res_freq),
    .res_i(res_i), .res_q(res_q), .res_mag_sq(res_mag_sq), .res_last(res_last)
`ifdef SWEEP_PEAK_EN
    , .peak_freq(peak_freq), .peak_mag(peak_mag)
`endif
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int valid_cyc = 0;
  logic [FREQ_W-1:0] rec_freq[$];
  logic              rec_last[$];
  logic [MAG_W-1:0]  rec_mag[$];

  // Posedge monitor sees pre-update outputs and stable inputs.
  always @(posedge clk) begin
    if (done) done_cnt++;
    if (res_valid) valid_cyc++;
    if (res_valid && res_ready) begin
      rec_freq.push_back(res_freq);
      rec_last.push_back(res_last);
      rec_mag.push_back(res_mag_sq);
    end
  end

  typedef struct {
    int     i;
    int     q;
    int     exp_i;
    int     exp_q;
    longint exp_mag;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_iq(input int i, input int q);
    i_in = DATA_W'(i);
    q_in = DATA_W'(q);
  endtask

  task automatic clear_recs();
    rec_freq.delete();
    rec_last.delete();
    rec_mag.delete();
  endtask

  task automatic start_sweep(input int f0, input int step, input int n, input int settle);
    f_start   = FREQ_W'(f0);
    f_step    = FREQ_W'(step);
    n_points  = 16'(n);
    settle_us = US_W'(settle);
    start     = 1'b1;
    tick(1);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    int k = 0;
    while (done_cnt == base && k < budget) begin
      tick(1);
      k++;
    end
    check(name, done_cnt - base, 1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k = 0;
    while (!res_valid && k < budget) begin
      tick(1);
      k++;
    end
    check(name, res_valid, 1);
  endtask

  task automatic wait_recs(input int n, input int budget, input string name);
    int k = 0;
    while (rec_freq.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check(name, rec_freq.size(), n);
  endtask

  initial begin
    int base, lat, vcnt;
    vecs[0] = '{40, -30, 40, -30, 2500};
    vecs[1] = '{-512, -512, -512, -512, 524288};
    vecs[2] = '{511, 511, 511, 511, 522242};
    vecs[3] = '{0, 0, 0, 0, 0};
    vecs[4] = '{-1, -1, -1, -1, 2};
    vecs[5] = '{5, -7, 5, -7, 74};
    vecs[6] = '{-512, 511, -512, 511, 523265};

    rst = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    f_start = '0; f_step = '0; n_points = 16'd0; settle_us = '0;
    set_iq(0, 0);
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", res_valid, 0);
    check("rst_freq_o", freq_o, 0);
    check("rst_mag", res_mag_sq, 0);
    check("rst_res_i", res_i, 0);
    rst = 1'b1;
    tick(2);

    // Single-point sweeps from the vector table.
    for (int k = 0; k < 7; k++) begin
      base = done_cnt;
      set_iq(vecs[k].i, vecs[k].q);
      start_sweep(1000 + k, 1, 1, 0);
      wait_done(base, 100, "vec_done");
      check("vec_res_i", res_i, vecs[k].exp_i);
      check("vec_res_q", res_q, vecs[k].exp_q);
      check("vec_mag", res_mag_sq, vecs[k].exp_mag);
      check("vec_last", res_last, 1);
      check("vec_freq", res_freq, 1000 + k);
      tick(1);
    end

    // Three-point sweep; config changed after start must be ignored.
    clear_recs();
    base = done_cnt;
    set_iq(40, -30);
    start_sweep(100, 10, 3, 0);
    f_step = FREQ_W'(999); n_points = 16'd0; settle_us = US_W'(7);
    wait_done(base, 300, "t1_done");
    check("t1_count", rec_freq.size(), 3);
    if (rec_freq.size() == 3) begin
      for (int p = 0; p < 3; p++) begin
        check("t1_freq", rec_freq[p], 100 + 10 * p);
        check("t1_last", rec_last[p], (p == 2) ? 1 : 0);
        check("t1_mag", rec_mag[p], 2500);
      end
    end
    tick(3);
    check("t1_one_done", done_cnt - base, 1);
    check("t1_idle", busy, 0);
    check("t1_freq_hold", freq_o, 120);

    // Latency from start to res_valid for settle 0 and 1 us.
    for (int s = 0; s < 2; s++) begin
      base = done_cnt;
      start_sweep(50, 1, 1, s);
      lat = 0;
      while (!res_valid && lat < 200) begin
        tick(1);
        lat++;
      end
      check("latency", lat, (s == 0) ? 18 : 67);
      wait_done(base, 20, "lat_done");
      tick(1);
    end

    // Backpressure: record held stable, stray start ignored.
    clear_recs();
    base = done_cnt;
    res_ready = 1'b0;
    set_iq(-20, 15);
    start_sweep(200, 7, 2, 0);
    wait_valid(100, "t2_valid");
    f_start = FREQ_W'(3000); start = 1'b1; tick(1); start = 1'b0;
    tick(19);
    check("t2_valid_held", res_valid, 1);
    check("t2_res_freq", res_freq, 200);
    check("t2_freq_o", freq_o, 200);
    check("t2_mag", res_mag_sq, 625);
    check("t2_no_hs", rec_freq.size(), 0);
    res_ready = 1'b1;
    tick(1);
    check("t2_valid_drop", res_valid, 0);
    wait_done(base, 100, "t2_done");
    check("t2_count", rec_freq.size(), 2);
    if (rec_freq.size() == 2) check("t2_freq2", rec_freq[1], 207);
    tick(1);

    // Alternating extremes average to -0.5, floored to -1.
    base = done_cnt;
    set_iq(-512, -512);
    start_sweep(300, 1, 1, 0);
    lat = 0;
    while (!res_valid && lat < 100) begin
      i_in = (i_in == -DATA_W'(512)) ? DATA_W'(511) : DATA_W'(-512);
      tick(1);
      lat++;
    end
    check("t3_res_i", res_i, -1);
    check("t3_res_q", res_q, -512);
    check("t3_mag", res_mag_sq, 262145);
    wait_done(base, 20, "t3_done");
    tick(1);

    // Abort during accumulation of the second point.
    clear_recs();
    base = done_cnt;
    set_iq(3, 4);
    start_sweep(100, 10, 3, 0);
    wait_recs(1, 100, "t4_first_rec");
    tick(5);
    abort = 1'b1; tick(1); abort = 1'b0;
    check("t4_idle", busy, 0);
    check("t4_valid", res_valid, 0);
    check("t4_freq_hold", freq_o, 110);
    tick(40);
    check("t4_no_done", done_cnt - base, 0);
    check("t4_no_more_rec", rec_freq.size(), 1);

    // Abort coinciding with a handshake wins.
    base = done_cnt;
    start_sweep(400, 10, 2, 0);
    wait_valid(100, "t4b_valid");
    abort = 1'b1; tick(1); abort = 1'b0;
    check("t4b_idle", busy, 0);
    check("t4b_valid", res_valid, 0);
    tick(40);
    check("t4b_no_done", done_cnt - base, 0);
    check("t4b_freq_hold", freq_o, 400);
    base = done_cnt;
    start_sweep(500, 1, 1, 0);
    wait_done(base, 100, "t4b_restart_done");
    check("t4b_restart_mag", res_mag_sq, 25);
    tick(1);

    // Empty sweep and frequency wrap.
    base = done_cnt;
    vcnt = valid_cyc;
    start_sweep(600, 1, 0, 0);
    wait_done(base, 3, "t5_empty_done");
    tick(3);
    check("t5_no_valid", valid_cyc - vcnt, 0);
    check("t5_one_done", done_cnt - base, 1);
    check("t5_idle", busy, 0);
    clear_recs();
    base = done_cnt;
    start_sweep(16380, 5, 2, 0);
    wait_done(base, 100, "t5_wrap_done");
    check("t5_wrap_count", rec_freq.size(), 2);
    if (rec_freq.size() == 2) begin
      check("t5_wrap_f0", rec_freq[0], 16380);
      check("t5_wrap_f1", rec_freq[1], 1);
    end
    check("t5_freq_o", freq_o, 1);
    tick(1);

    // Four points with magnitudes 100, 900, 900, 400.
    clear_recs();
    base = done_cnt;
    set_iq(10, 0);
    start_sweep(700, 3, 4, 1);
    for (int p = 1; p < 4; p++) begin
      wait_recs(p, 200, "t6_rec");
      case (p)
        1: set_iq(30, 0);
        2: set_iq(0, -30);
        default: set_iq(-20, 0);
      endcase
    end
    wait_done(base, 200, "t6_done");
    check("t6_count", rec_mag.size(), 4);
    if (rec_mag.size() == 4) begin
      check("t6_mag0", rec_mag[0], 100);
      check("t6_mag1", rec_mag[1], 900);
      check("t6_mag2", rec_mag[2], 900);
      check("t6_mag3", rec_mag[3], 400);
    end
`ifdef SWEEP_PEAK_EN
    check("t6_peak_mag", peak_mag, 900);
    check("t6_peak_freq", peak_freq, 703);
`endif
    tick(1);

    // Reset in the middle of a sweep clears every output.
    set_iq(9, 9);
    start_sweep(800, 1, 3, 1);
    tick(60);
    rst = 1'b0;
    tick(1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_valid", res_valid, 0);
    check("t6_rst_freq_o", freq_o, 0);
    check("t6_rst_res_freq", res_freq, 0);
    check("t6_rst_mag", res_mag_sq, 0);
    check("t6_rst_res_i", res_i, 0);
    check("t6_rst_last", res_last, 0);
`ifdef SWEEP_PEAK_EN
    check("t6_rst_peak", peak_mag, 0);
`endif
    rst = 1'b1;
    tick(5);
    check("t6_post_rst_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
